mem_cache_controller: RTL and testbench

//  2-way set-associative, write-through, no-write-allocate data cache between MEM stage and SRAM controller.

---
 rtl/mem_cache_controller.sv | 173 +++++++++++++++++
 tb/tb_mem_cache_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cache_controller.sv
// mem_cache_controller: 2-way set-associative, write-through, no-write-allocate
// data cache between the MEM stage and the SRAM controller. Read hits return
// data in the same cycle; misses and all stores go through the SRAM handshake.
// Optional build macro CACHE_STATS_EN adds load hit/miss counters.
module mem_cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          SETS      = 64,
  parameter int          TAG_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  input  logic [63:0] sram_rdata,
`ifdef CACHE_STATS_EN
  input  logic        sram_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`else
  input  logic        sram_ready
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TOP   = 3 + IDX_W + TAG_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state_reg, state_next;

  logic [31:0]      eff;
  logic             word_sel;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             unused_eff_bits;

  logic [1:0][SETS-1:0] valid_reg;
  logic [SETS-1:0]      lru_reg;

  logic [1:0]  hit_way;
  logic [31:0] way_word [2];
  logic        hit;
  logic        hit_w;
  logic        victim;
  logic        do_rd_hit;
  logic        do_store;
  logic        do_fill;
  logic        store_hit;

  assign eff             = addr - BASE_ADDR;
  assign word_sel        = eff[2];
  assign index           = eff[3 +: IDX_W];
  assign tag             = eff[3 + IDX_W +: TAG_W];
  assign unused_eff_bits = ^{eff[31:TOP], eff[1:0]};

  assign hit       = |hit_way;
  assign hit_w     = hit_way[1];
  assign store_hit = do_store && hit;
  // First invalid way wins (way 0 first); otherwise the LRU bit names the victim.
  assign victim    = !valid_reg[0][index] ? 1'b0 :
                     !valid_reg[1][index] ? 1'b1 : lru_reg[index];

  assign sram_address = addr;
  assign sram_wdata   = wdata;
  assign sram_r_en    = (state_reg == FILL);
  assign sram_w_en    = (state_reg == WRITE);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic [63:0]      line_mem [SETS];
      logic [TAG_W-1:0] tag_mem  [SETS];
      logic [63:0]      cur_line;

      assign cur_line     = line_mem[index];
      assign hit_way[gi]  = valid_reg[gi][index] && (tag_mem[index] == tag);
      assign way_word[gi] = word_sel ? cur_line[63:32] : cur_line[31:0];

      // Line/tag storage: whole-line fill on miss, single-word update on store hit.
      always_ff @(posedge clk) begin
        if (do_fill && (victim == gi[0])) begin
          line_mem[index] <= sram_rdata;
          tag_mem[index]  <= tag;
        end else if (store_hit && (hit_w == gi[0])) begin
          if (word_sel) line_mem[index][63:32] <= wdata;
          else          line_mem[index][31:0]  <= wdata;
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, pipeline ready and load data.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b1;
    rdata      = 32'd0;
    do_rd_hit  = 1'b0;
    do_store   = 1'b0;
    do_fill    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_w_en) begin
          ready      = 1'b0;
          do_store   = 1'b1;
          state_next = WRITE;
        end else if (mem_r_en) begin
          if (hit) begin
            rdata     = way_word[hit_w];
            do_rd_hit = 1'b1;
          end else begin
            ready      = 1'b0;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        ready = sram_ready;
        if (sram_ready) begin
          rdata      = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
          do_fill    = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        ready = sram_ready;
        if (sram_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Valid and LRU bits; the LRU bit always points away from the way just used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      lru_reg   <= '0;
    end else begin
      if (do_rd_hit || store_hit) lru_reg[index] <= ~hit_w;
      if (do_fill) begin
        valid_reg[victim][index] <= 1'b1;
        lru_reg[index]           <= ~victim;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Load statistics: one hit per zero-wait load, one miss per fill started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      if (do_rd_hit) hit_count <= hit_count + 16'd1;
      if (state_reg == IDLE && state_next == FILL) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_cache_controller.sv
// Bench for mem_cache_controller: directed scenarios plus random loads/stores.
// The reference is a flat memory (write-through keeps cache == memory) and a
// per-set tag/valid/LRU directory predicting hit or miss for each request.
module tb_mem_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] sram_rdata = 64'd0;
  logic        sram_ready = 1'b0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  mem_cache_controller dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_rdata(sram_rdata),
`ifdef CACHE_STATS_EN
    .sram_ready(sram_ready), .hit_count(hit_count), .miss_count(miss_count)
`else
    .sram_ready(sram_ready)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations, written by the driver just after each rising edge.
  bit          chk_en = 1'b0;
  bit          exp_ready, exp_sr, exp_sw, exp_rv;
  logic [31:0] exp_rdata;

  // Reference state.
  logic [63:0] mem [int unsigned];
  bit          mvalid [64][2];
  bit [9:0]    mtag   [64][2];
  bit          mlru   [64];
  int          n_hits = 0;
  int          n_misses = 0;

  // Single compare process: every checked cycle, at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ready !== exp_ready) begin
        errors++;
        $display("FAIL ready t=%0t addr=%h got %b want %b", $time, addr, ready, exp_ready);
      end
      checks++;
      if (sram_r_en !== exp_sr) begin
        errors++;
        $display("FAIL sram_r_en t=%0t addr=%h got %b want %b", $time, addr, sram_r_en, exp_sr);
      end
      checks++;
      if (sram_w_en !== exp_sw) begin
        errors++;
        $display("FAIL sram_w_en t=%0t addr=%h got %b want %b", $time, addr, sram_w_en, exp_sw);
      end
      checks++;
      if (sram_address !== addr) begin
        errors++;
        $display("FAIL sram_address t=%0t got %h want %h", $time, sram_address, addr);
      end
      if (exp_sw) begin
        checks++;
        if (sram_wdata !== wdata) begin
          errors++;
          $display("FAIL sram_wdata t=%0t got %h want %h", $time, sram_wdata, wdata);
        end
      end
      if (exp_rv) begin
        checks++;
        if (rdata !== exp_rdata) begin
          errors++;
          $display("FAIL rdata t=%0t addr=%h got %h want %h", $time, addr, rdata, exp_rdata);
        end
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit r, input bit sr, input bit sw, input bit rv, input logic [31:0] d);
    exp_ready = r; exp_sr = sr; exp_sw = sw; exp_rv = rv; exp_rdata = d;
  endtask

  function automatic logic [63:0] mem_line(input int unsigned k);
    int unsigned lo, hi;
    if (mem.exists(k)) return mem[k];
    lo = k * 32'h85EB_CA6B;
    hi = (k * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    return {hi, lo};
  endfunction

  task automatic split(input logic [31:0] a, output int s, output bit [9:0] t);
    logic [31:0] e;
    e = a - 32'd1024;
    s = int'(e[8:3]);
    t = e[18:9];
  endtask

  task automatic lookup(input logic [31:0] a, output bit h, output int w);
    int s;
    bit [9:0] t;
    split(a, s, t);
    h = 1'b0;
    w = 0;
    for (int k = 0; k < 2; k++)
      if (mvalid[s][k] && mtag[s][k] == t) begin h = 1'b1; w = k; end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      mvalid[s][0] = 1'b0; mvalid[s][1] = 1'b0; mlru[s] = 1'b0;
    end
  endtask

  // One load; lit_en pins the returned word to a hand-computed constant.
  task automatic do_load(input logic [31:0] a, input bit lit_en, input logic [31:0] lit, input string name);
    bit h;
    int w, s, lat, v;
    bit [9:0] t;
    logic [63:0] line;
    logic [31:0] word;
    lookup(a, h, w);
    split(a, s, t);
    line = mem_line(a >> 3);
    word = a[2] ? line[63:32] : line[31:0];
    addr = a; mem_r_en = 1'b1; mem_w_en = 1'b0; sram_ready = 1'b0;
    if (h) begin
      set_exp(1, 0, 0, 1, word);
      if (lit_en) begin @(negedge clk); check_lit(name, rdata, lit); end
      step();
      mlru[s] = ~w[0];
      n_hits++;
    end else begin
      set_exp(0, 0, 0, 0, 0);
      step();
      n_misses++;
      lat = $urandom_range(0, 3);
      repeat (lat) begin set_exp(0, 1, 0, 0, 0); step(); end
      sram_ready = 1'b1; sram_rdata = line;
      set_exp(1, 1, 0, 1, word);
      if (lit_en) begin @(negedge clk); check_lit(name, rdata, lit); end
      step();
      v = !mvalid[s][0] ? 0 : (!mvalid[s][1] ? 1 : int'(mlru[s]));
      mvalid[s][v] = 1'b1; mtag[s][v] = t; mlru[s] = ~v[0];
    end
    $display("load  addr=%h %s data=%h", a, h ? "hit " : "miss", word);
    mem_r_en = 1'b0; sram_ready = 1'b0;
    set_exp(1, 0, 0, 0, 0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit also_rd);
    bit h;
    int w, s, lat;
    bit [9:0] t;
    logic [63:0] line;
    lookup(a, h, w);
    split(a, s, t);
    addr = a; wdata = d; mem_w_en = 1'b1; mem_r_en = also_rd; sram_ready = 1'b0;
    set_exp(0, 0, 0, 0, 0);
    step();
    if (h) mlru[s] = ~w[0];
    lat = $urandom_range(0, 3);
    repeat (lat) begin set_exp(0, 0, 1, 0, 0); step(); end
    sram_ready = 1'b1;
    set_exp(1, 0, 1, 0, 0);
    step();
    line = mem_line(a >> 3);
    if (a[2]) line[63:32] = d; else line[31:0] = d;
    mem[a >> 3] = line;
    $display("store addr=%h %s data=%h rd=%0d", a, h ? "hit " : "miss", d, also_rd);
    mem_w_en = 1'b0; mem_r_en = 1'b0; sram_ready = 1'b0;
    set_exp(1, 0, 0, 0, 0);
  endtask

  task automatic do_idle(input bit stray_ready);
    mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = stray_ready;
    set_exp(1, 0, 0, 0, 0);
    step();
    sram_ready = 1'b0;
    $display("idle  stray_ready=%0d", stray_ready);
  endtask

  initial begin
    logic [31:0] a;
    int op;
    model_reset();
    mem[32'd1024 >> 3] = 64'hBBBB_0000_AAAA_0000;
    // Reset state with no request pending.
    step();
    chk_en = 1'b1;
    set_exp(1, 0, 0, 1, 32'd0);
    step();
    rst = 1'b0;
    set_exp(1, 0, 0, 0, 0);
    step();

    // Fill on first load, then hit on the odd word of the same line.
    do_load(32'd1024, 1, 32'hAAAA_0000, "fill_even_word");
    do_load(32'd1028, 1, 32'hBBBB_0000, "hit_odd_word");
    // Two ways of set 0, then a third tag evicts the LRU way (tag 1).
    do_load(32'd1536, 0, 0, "");
    do_load(32'd1024, 0, 0, "");
    do_load(32'd2048, 0, 0, "");
    do_load(32'd1024, 0, 0, "");
    do_load(32'd1536, 0, 0, "");
    // Store hit updates the cached word.
    do_store(32'd1024, 32'h0000_1234, 0);
    do_load(32'd1024, 1, 32'h0000_1234, "store_hit_readback");
    // Store miss does not allocate.
    do_store(32'd4096, 32'hCAFE_F00D, 0);
    do_load(32'd4096, 1, 32'hCAFE_F00D, "store_miss_readback");
    do_idle(1'b1);

    // Reset in the middle of a fill.
    addr = 32'd8192; mem_r_en = 1'b1;
    set_exp(0, 0, 0, 0, 0);
    step();
    set_exp(0, 1, 0, 0, 0);
    step();
    rst = 1'b1; mem_r_en = 1'b0;
    set_exp(1, 0, 0, 0, 0);
    @(negedge clk);
    check_lit("rst_mid_fill_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    step();
    rst = 1'b0;
    model_reset();
`ifdef CACHE_STATS_EN
    n_hits = 0; n_misses = 0;
`endif
    step();
    do_load(32'd8192, 0, 0, "");
    do_load(32'd1024, 1, 32'h0000_1234, "reload_after_rst");

    // Random traffic over a few sets and tags to force conflicts.
    for (int i = 0; i < 400; i++) begin
      a = 32'd1024 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 2) << 3)
          + ($urandom_range(0, 1) << 2) + $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op < 6)       do_load(a, 0, 0, "");
      else if (op < 8)  do_store(a, $urandom, 0);
      else if (op == 8) do_store(a, $urandom, 1);
      else              do_idle($urandom_range(0, 1));
    end

`ifdef CACHE_STATS_EN
    @(negedge clk);
    check_lit("hit_count", {16'd0, hit_count}, n_hits);
    check_lit("miss_count", {16'd0, miss_count}, n_misses);
`endif
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
